// File: rtl/cm0_dbg_ap_mst.sv
// Debug access-port initiator for the Cortex-M0 debug SLV port.
// Turns byte/halfword/word commands into two-phase SLV transfers, one transfer at a time,
// with a transfer address register (TAR), optional wrapping auto-increment and a sticky error.
module cm0_dbg_ap_mst #(
  parameter int unsigned INCR_WRAP = 10
) (
  input  logic        dclk,
  input  logic        dbg_reset,
  input  logic        cmd_valid_i,
  output logic        cmd_ready_o,
  input  logic        cmd_ld_tar_i,
  input  logic [31:0] cmd_addr_i,
  input  logic        cmd_write_i,
  input  logic [1:0]  cmd_size_i,
  input  logic        cmd_incr_i,
  input  logic [31:0] cmd_wdata_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] rsp_rdata_o,
  output logic        rsp_err_o,
  output logic        err_sticky_o,
  input  logic        clr_err_i,
  output logic [31:0] tar_o,
  output logic [31:0] slv_addr_o,
  output logic [1:0]  slv_size_o,
  output logic [1:0]  slv_trans_o,
  output logic        slv_write_o,
  output logic [31:0] slv_wdata_o,
  input  logic [31:0] slv_rdata_i,
  input  logic        slv_ready_i,
  input  logic        slv_resp_i
);

  localparam logic [1:0] TransIdle   = 2'b00;
  localparam logic [1:0] TransNonseq = 2'b10;

  typedef enum logic [1:0] {StIdle, StAddr, StData, StResp} state_e;

  state_e      state_q;
  logic        incr_q;
  logic [31:0] wdata_q;

  logic        accept;
  logic        reject;
  logic [31:0] eff_tar;
  logic [31:0] wdata_rep;
  logic [31:0] rd_shift;
  logic [31:0] rd_sized;
  logic [2:0]  step;
  logic [31:0] tar_inc;

  // Only accept in IDLE, and never while reset is being applied.
  assign cmd_ready_o = (state_q == StIdle) && !dbg_reset;
  assign accept      = cmd_valid_i && cmd_ready_o;

  // The access always uses the TAR value that will be in place after an optional load.
  assign eff_tar = cmd_ld_tar_i ? cmd_addr_i : tar_o;

  // Decide at accept whether the command may reach the SLV port at all.
  always_comb begin
    reject = err_sticky_o;
    unique case (cmd_size_i)
      2'b00:   reject = reject;
      2'b01:   reject = reject || eff_tar[0];
      2'b10:   reject = reject || (eff_tar[1:0] != 2'b00);
      default: reject = 1'b1;
    endcase
  end

  // Replicate write data across byte lanes according to access size.
  always_comb begin
    wdata_rep = cmd_wdata_i;
    case (cmd_size_i)
      2'b00:   wdata_rep = {4{cmd_wdata_i[7:0]}};
      2'b01:   wdata_rep = {2{cmd_wdata_i[15:0]}};
      default: wdata_rep = cmd_wdata_i;
    endcase
  end

  // Right-justify read data from its byte lane and zero-extend to the access size.
  always_comb begin
    rd_shift = slv_rdata_i >> {tar_o[1:0], 3'b000};
    rd_sized = rd_shift;
    case (slv_size_o)
      2'b00:   rd_sized = {24'h0, rd_shift[7:0]};
      2'b01:   rd_sized = {16'h0, rd_shift[15:0]};
      default: rd_sized = rd_shift;
    endcase
  end

  // Wrapping increment: only the low INCR_WRAP bits of TAR move.
  always_comb begin
    step                     = 3'b001 << slv_size_o;
    tar_inc                  = tar_o;
    tar_inc[INCR_WRAP-1:0]   = tar_o[INCR_WRAP-1:0] + INCR_WRAP'(step);
  end

  // Transfer FSM with all outputs registered.
  always_ff @(posedge dclk) begin
    if (dbg_reset) begin
      state_q      <= StIdle;
      incr_q       <= 1'b0;
      wdata_q      <= 32'h0;
      tar_o        <= 32'h0;
      err_sticky_o <= 1'b0;
      rsp_valid_o  <= 1'b0;
      rsp_rdata_o  <= 32'h0;
      rsp_err_o    <= 1'b0;
      slv_addr_o   <= 32'h0;
      slv_size_o   <= 2'b00;
      slv_trans_o  <= TransIdle;
      slv_write_o  <= 1'b0;
      slv_wdata_o  <= 32'h0;
    end else begin
      // A set later in this block overrides the clear.
      if (clr_err_i) begin
        err_sticky_o <= 1'b0;
      end
      case (state_q)
        StIdle: begin
          if (accept) begin
            // The TAR load is part of the command and happens even if the access is rejected.
            if (cmd_ld_tar_i) begin
              tar_o <= cmd_addr_i;
            end
            if (reject) begin
              state_q      <= StResp;
              rsp_valid_o  <= 1'b1;
              rsp_err_o    <= 1'b1;
              rsp_rdata_o  <= 32'h0;
              err_sticky_o <= 1'b1;
            end else begin
              state_q     <= StAddr;
              slv_trans_o <= TransNonseq;
              slv_addr_o  <= eff_tar;
              slv_size_o  <= cmd_size_i;
              slv_write_o <= cmd_write_i;
              incr_q      <= cmd_incr_i;
              wdata_q     <= wdata_rep;
            end
          end
        end
        StAddr: begin
          state_q     <= StData;
          slv_trans_o <= TransIdle;
          if (slv_write_o) begin
            slv_wdata_o <= wdata_q;
          end
        end
        StData: begin
          if (slv_ready_i) begin
            state_q     <= StResp;
            slv_wdata_o <= 32'h0;
            rsp_valid_o <= 1'b1;
            rsp_err_o   <= slv_resp_i;
            rsp_rdata_o <= slv_write_o ? 32'h0 : rd_sized;
            if (slv_resp_i) begin
              err_sticky_o <= 1'b1;
            end else if (incr_q) begin
              tar_o <= tar_inc;
            end
          end
        end
        StResp: begin
          if (rsp_ready_i) begin
            state_q     <= StIdle;
            rsp_valid_o <= 1'b0;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cm0_dbg_ap_mst.sv
// Self-checking bench for cm0_dbg_ap_mst: directed cases plus randomized commands,
// checked against a command-level model of TAR, sticky error, latency and data lanes.
module tb_cm0_dbg_ap_mst;

  localparam int unsigned WrapBytes = 1024;

  logic        dclk = 1'b0;
  logic        dbg_reset;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic        cmd_ld_tar_i;
  logic [31:0] cmd_addr_i;
  logic        cmd_write_i;
  logic [1:0]  cmd_size_i;
  logic        cmd_incr_i;
  logic [31:0] cmd_wdata_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [31:0] rsp_rdata_o;
  logic        rsp_err_o;
  logic        err_sticky_o;
  logic        clr_err_i;
  logic [31:0] tar_o;
  logic [31:0] slv_addr_o;
  logic [1:0]  slv_size_o;
  logic [1:0]  slv_trans_o;
  logic        slv_write_o;
  logic [31:0] slv_wdata_o;
  logic [31:0] slv_rdata_i;
  logic        slv_ready_i;
  logic        slv_resp_i;

  int          n_total = 0;
  int          n_pass  = 0;
  logic [31:0] m_tar;
  logic        m_sticky;
  logic [31:0] last_rd;

  always #5 dclk = ~dclk;

  cm0_dbg_ap_mst #(.INCR_WRAP(10)) dut (
    .dclk        (dclk),
    .dbg_reset   (dbg_reset),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_ld_tar_i(cmd_ld_tar_i),
    .cmd_addr_i  (cmd_addr_i),
    .cmd_write_i (cmd_write_i),
    .cmd_size_i  (cmd_size_i),
    .cmd_incr_i  (cmd_incr_i),
    .cmd_wdata_i (cmd_wdata_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_ready_i (rsp_ready_i),
    .rsp_rdata_o (rsp_rdata_o),
    .rsp_err_o   (rsp_err_o),
    .err_sticky_o(err_sticky_o),
    .clr_err_i   (clr_err_i),
    .tar_o       (tar_o),
    .slv_addr_o  (slv_addr_o),
    .slv_size_o  (slv_size_o),
    .slv_trans_o (slv_trans_o),
    .slv_write_o (slv_write_o),
    .slv_wdata_o (slv_wdata_o),
    .slv_rdata_i (slv_rdata_i),
    .slv_ready_i (slv_ready_i),
    .slv_resp_i  (slv_resp_i)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge dclk);
    #1;
  endtask

  task automatic clear_err();
    clr_err_i = 1'b1;
    tick();
    clr_err_i = 1'b0;
    m_sticky  = 1'b0;
    check("clr_sticky", {31'h0, err_sticky_o}, 32'h0);
  endtask

  // One complete command: accept, optional SLV transfer with `waits` wait states, response
  // held for `rdly` cycles. `clr` pulses clr_err_i in the cycle just before RESP is entered.
  task automatic run_cmd(input logic ld, input logic [31:0] addr, input logic wr,
                         input logic [1:0] sz, input logic inc, input logic [31:0] wd,
                         input int waits, input logic serr, input logic [31:0] rword,
                         input int rdly, input logic clr);
    logic [31:0] eff, exp_wd, exp_rd;
    logic        rej, exp_err;
    int unsigned lo;
    eff = ld ? addr : m_tar;
    rej = m_sticky || (sz == 2'b11) || (sz == 2'b01 && eff[0]) ||
          (sz == 2'b10 && eff[1:0] != 2'b00);
    m_tar = eff;
    case (sz)
      2'b00:   exp_wd = {4{wd[7:0]}};
      2'b01:   exp_wd = {2{wd[15:0]}};
      default: exp_wd = wd;
    endcase
    exp_rd = rword >> (8 * eff[1:0]);
    if (sz == 2'b00) exp_rd = exp_rd & 32'h0000_00FF;
    if (sz == 2'b01) exp_rd = exp_rd & 32'h0000_FFFF;

    check("idle_ready", {31'h0, cmd_ready_o}, 32'h1);
    cmd_valid_i  = 1'b1;
    cmd_ld_tar_i = ld;
    cmd_addr_i   = addr;
    cmd_write_i  = wr;
    cmd_size_i   = sz;
    cmd_incr_i   = inc;
    cmd_wdata_i  = wd;
    clr_err_i    = rej && clr;
    tick();
    cmd_valid_i = 1'b0;
    cmd_addr_i  = $urandom;
    cmd_wdata_i = $urandom;
    clr_err_i   = 1'b0;

    if (rej) begin
      exp_err = 1'b1;
      check("rej_rsp_valid", {31'h0, rsp_valid_o}, 32'h1);
      check("rej_trans", {30'h0, slv_trans_o}, 32'h0);
    end else begin
      exp_err = serr;
      check("addr_trans", {30'h0, slv_trans_o}, 32'h2);
      check("addr_addr", slv_addr_o, eff);
      check("addr_size", {30'h0, slv_size_o}, {30'h0, sz});
      check("addr_write", {31'h0, slv_write_o}, {31'h0, wr});
      check("addr_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
      tick();
      for (int w = 0; w <= waits; w++) begin
        check("data_trans", {30'h0, slv_trans_o}, 32'h0);
        check("data_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
        check("data_addr", slv_addr_o, eff);
        if (wr) check("data_wdata", slv_wdata_o, exp_wd);
        slv_ready_i = (w == waits);
        slv_rdata_i = (w == waits) ? rword : $urandom;
        slv_resp_i  = (w == waits) ? serr : 1'($urandom);
        clr_err_i   = (w == waits) && clr;
        tick();
      end
      slv_ready_i = 1'b0;
      slv_resp_i  = 1'b0;
      slv_rdata_i = $urandom;
      clr_err_i   = 1'b0;
      check("rsp_valid", {31'h0, rsp_valid_o}, 32'h1);
      check("rsp_trans", {30'h0, slv_trans_o}, 32'h0);
    end

    check("rsp_err", {31'h0, rsp_err_o}, {31'h0, exp_err});
    if (!rej && !wr && !serr) check("rsp_rdata", rsp_rdata_o, exp_rd);
    if (exp_err) begin
      m_sticky = 1'b1;
    end else begin
      if (clr) m_sticky = 1'b0;
      if (inc) begin
        lo    = (m_tar % WrapBytes + (1 << sz)) % WrapBytes;
        m_tar = m_tar - (m_tar % WrapBytes) + lo;
      end
    end
    check("tar", tar_o, m_tar);
    check("sticky", {31'h0, err_sticky_o}, {31'h0, m_sticky});
    last_rd = rsp_rdata_o;

    for (int d = 0; d < rdly; d++) begin
      tick();
      check("hold_valid", {31'h0, rsp_valid_o}, 32'h1);
      check("hold_err", {31'h0, rsp_err_o}, {31'h0, exp_err});
      check("hold_rdata", rsp_rdata_o, last_rd);
    end
    rsp_ready_i = 1'b1;
    tick();
    rsp_ready_i = 1'b0;
    check("done_valid", {31'h0, rsp_valid_o}, 32'h0);
    check("done_ready", {31'h0, cmd_ready_o}, 32'h1);
  endtask

  initial begin
    dbg_reset    = 1'b1;
    cmd_valid_i  = 1'b0;
    cmd_ld_tar_i = 1'b0;
    cmd_addr_i   = 32'h0;
    cmd_write_i  = 1'b0;
    cmd_size_i   = 2'b00;
    cmd_incr_i   = 1'b0;
    cmd_wdata_i  = 32'h0;
    rsp_ready_i  = 1'b0;
    clr_err_i    = 1'b0;
    slv_rdata_i  = 32'h0;
    slv_ready_i  = 1'b0;
    slv_resp_i   = 1'b0;
    m_tar        = 32'h0;
    m_sticky     = 1'b0;
    last_rd      = 32'h0;
    tick();
    tick();
    dbg_reset = 1'b0;
    #1;
    check("rst_tar", tar_o, 32'h0);
    check("rst_sticky", {31'h0, err_sticky_o}, 32'h0);
    check("rst_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    check("rst_trans", {30'h0, slv_trans_o}, 32'h0);
    check("rst_addr", slv_addr_o, 32'h0);
    check("rst_wdata", slv_wdata_o, 32'h0);
    check("rst_cmd_ready", {31'h0, cmd_ready_o}, 32'h1);

    // Word write with TAR load, no wait states.
    run_cmd(1'b1, 32'hE000_EDF0, 1'b1, 2'b10, 1'b0, 32'h1234_5678, 0, 1'b0, 32'h0, 1, 1'b0);
    check("t1_tar", tar_o, 32'hE000_EDF0);

    // Byte read from lane 3 with two wait states.
    run_cmd(1'b1, 32'h2000_0003, 1'b0, 2'b00, 1'b0, 32'h0, 2, 1'b0, 32'hAB00_0000, 0, 1'b0);
    check("t2_rdata", last_rd, 32'h0000_00AB);

    // Halfword write with increment across the 1KB wrap.
    run_cmd(1'b1, 32'h2000_03FE, 1'b1, 2'b01, 1'b1, 32'h0000_BEEF, 0, 1'b0, 32'h0, 0, 1'b0);
    check("t3_tar", tar_o, 32'h2000_0000);

    // SLV error sets sticky; following command is rejected until cleared.
    run_cmd(1'b0, 32'h0, 1'b0, 2'b10, 1'b1, 32'h0, 1, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
    check("t4_sticky", {31'h0, err_sticky_o}, 32'h1);
    run_cmd(1'b0, 32'h0, 1'b0, 2'b10, 1'b0, 32'h0, 0, 1'b0, 32'h0, 0, 1'b0);
    clear_err();
    run_cmd(1'b0, 32'h0, 1'b0, 2'b10, 1'b1, 32'h0, 0, 1'b0, 32'hCAFE_F00D, 0, 1'b0);
    check("t4_tar_after", tar_o, 32'h2000_0004);

    // Misaligned word and reserved size are rejected with TAR untouched.
    run_cmd(1'b1, 32'h0000_1002, 1'b0, 2'b00, 1'b0, 32'h0, 0, 1'b0, 32'h0055_0000, 0, 1'b0);
    run_cmd(1'b0, 32'h0, 1'b0, 2'b10, 1'b1, 32'h0, 0, 1'b0, 32'h0, 0, 1'b0);
    check("t5_tar", tar_o, 32'h0000_1002);
    clear_err();
    run_cmd(1'b0, 32'h0, 1'b1, 2'b11, 1'b1, 32'h0, 0, 1'b0, 32'h0, 0, 1'b0);
    check("t5_tar_sz3", tar_o, 32'h0000_1002);

    // Clear and set in the same cycle: the set wins.
    clear_err();
    run_cmd(1'b0, 32'h0, 1'b0, 2'b00, 1'b0, 32'h0, 0, 1'b1, 32'h0, 0, 1'b1);
    check("setwins_sticky", {31'h0, err_sticky_o}, 32'h1);
    clear_err();

    // Randomized commands.
    for (int i = 0; i < 60; i++) begin
      logic        r_ld;
      logic [31:0] r_addr;
      logic [1:0]  r_sz;
      if (m_sticky && ($urandom_range(0, 1) == 1)) clear_err();
      r_ld   = ($urandom_range(0, 2) == 0);
      r_addr = $urandom;
      if ($urandom_range(0, 1) == 1) r_addr[1:0] = 2'b00;
      r_sz   = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
      run_cmd(r_ld, r_addr, 1'($urandom), r_sz, 1'($urandom), $urandom,
              $urandom_range(0, 3), ($urandom_range(0, 7) == 0), $urandom,
              $urandom_range(0, 2), ($urandom_range(0, 7) == 0));
    end

    // Reset during DATA abandons the transfer.
    if (m_sticky) clear_err();
    cmd_valid_i  = 1'b1;
    cmd_ld_tar_i = 1'b1;
    cmd_addr_i   = 32'h2000_0010;
    cmd_write_i  = 1'b0;
    cmd_size_i   = 2'b10;
    tick();
    cmd_valid_i = 1'b0;
    tick();
    check("r6_in_data", {30'h0, slv_trans_o}, 32'h0);
    dbg_reset = 1'b1;
    tick();
    dbg_reset = 1'b0;
    #1;
    m_tar    = 32'h0;
    m_sticky = 1'b0;
    check("r6_trans", {30'h0, slv_trans_o}, 32'h0);
    check("r6_rsp_valid", {31'h0, rsp_valid_o}, 32'h0);
    check("r6_tar", tar_o, 32'h0);
    check("r6_cmd_ready", {31'h0, cmd_ready_o}, 32'h1);
    slv_ready_i = 1'b1;
    tick();
    slv_ready_i = 1'b0;
    check("r6_no_rsp", {31'h0, rsp_valid_o}, 32'h0);
    run_cmd(1'b0, 32'h0, 1'b0, 2'b10, 1'b1, 32'h0, 0, 1'b0, 32'h1357_9BDF, 0, 1'b0);
    check("r6_tar_after", tar_o, 32'h0000_0004);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
